fp_mult_pipe: RTL and testbench
===============================

Name: fp_mult_pipe

Overview:
Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier, the successor to the combinational single-precision normalise/round path. It generalises exponent and mantissa width and adds four rounding modes, special-value handling, exception flags and valid/ready flow control with per-stage stall. It sits between the operand issue logic and the FP writeback/flag register in the Mini-RISC-V FP unit.

Parameters:
EXP_W, 8, exponent field width (>=4); bias = 2^(EXP_W-1)-1
MAN_W, 23, stored fraction width (>=4); total word width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands a, b, rm are valid
in_ready  out  1  block accepts the operands this cycle
a  in  W  operand A
b  in  W  operand B
rm  in  2  rounding mode: 0=RNE, 1=RTZ, 2=RUP (toward +inf), 3=RDN (toward -inf)
out_valid  out  1  result p and flags are valid
out_ready  in  1  downstream accepts the result
p  out  W  packed product
flags  out  4  {NV, OF, UF, NX} = invalid, overflow, underflow, inexact

Behaviour:
- Reset (async, rst_n=0): all stage valid bits=0, out_valid=0, p=0, flags=0. Ops in flight are discarded. Outputs are held at 0 until the first result.
- Transfer on in_valid&in_ready (input) and out_valid&out_ready (output). rm is captured with the operands and travels with them.
- Stages: S1 unpack/classify + (MAN_W+1)x(MAN_W+1) significand multiply + exponent sum; S2 normalise (select product MSB, exponent +1) and extract guard/round/sticky; S3 round, overflow/underflow resolve, pack, drive p/flags.
- Stall: stage k loads when its valid=0 or stage k+1 loads this cycle; S3 loads when out_valid=0 or out_ready=1. in_ready = S1 loads condition. Bubbles collapse.
- Latency: 3 cycles from accept to out_valid with no stall; throughput 1/cycle.
- p/flags are stable while out_valid=1 and out_ready=0.
- Exponent arithmetic is signed, EXP_W+2 bits: e = ea+eb-bias (+1 if product MSB set) (+1 if rounding carries out).
- Inputs are classified as zero, subnormal, normal, inf, qNaN or sNaN. Subnormal inputs are treated as signed zero (DAZ). Result sign = sa^sb for non-NaN results.
- Rounding on the kept MAN_W+1 bits with G, R, S (S = OR of the rest):
  - RNE: up if G&(R|S|lsb).
  - RTZ: never up.
  - RUP: up if (G|R|S)&~sign.
  - RDN: up if (G|R|S)&sign.
  - A carry out of the significand renormalises (fraction=0) and increments e.
- Overflow (e >= 2^EXP_W-1): OF=NX=1.
  - RNE: inf.
  - RTZ: max finite.
  - RUP: +inf if positive, else -max finite.
  - RDN: -inf if negative, else +max finite.
- Underflow (e <= 0, nonzero exact product): flush to signed zero, UF=NX=1 (FTZ; no subnormal outputs).
- NX=1 whenever G|R|S are nonzero on a normal result.
- Specials (override the arithmetic, OF/UF/NX=0):
  - Any NaN input, or inf*zero: canonical qNaN {0, all-ones exp, 1, zeros}.
  - NV=1 for inf*zero or any sNaN input.
  - inf*nonzero: signed inf.
  - zero*finite: signed zero.
- Flags are per-result (not sticky); accumulation is the consumer's job.

Test Plan:
- Basic, RNE: 0x40400000*0x40000000 -> 0x40C00000, flags 0, out_valid exactly 3 cycles after accept.
- Rounding modes on 0x3F800001*0x3F800001 -> RNE 0x3F800002, RTZ 0x3F800002, RUP 0x3F800003, RDN 0x3F800002; NX=1 in every mode.
- Overflow on 0x7F7FFFFF*0x40000000 -> RNE 0x7F800000, RTZ 0x7F7FFFFF, flags OF|NX (0b0101). Sign-flipped A (0xFF7FFFFF) with RUP -> 0xFF7FFFFF.
- Specials:
  - 0x7F800000*0x00000000 -> 0x7FC00000, NV only.
  - 0x7F800001*0x3F800000 -> 0x7FC00000, NV.
  - 0xFF800000*0x40000000 -> 0xFF800000, flags 0.
- Underflow: 0x00800000*0x3F000000 -> 0x00000000, UF|NX. Subnormal input 0x00000001*0x7F000000 -> 0x00000000, flags 0.
- Backpressure/reset:
  - Stream 5 ops with out_ready=0: in_ready drops after 3 accepts, p holds the first result, and all 5 results emerge in order once out_ready=1.
  - Assert rst_n=0 mid-stream: out_valid=0, p=0 immediately, and no stale results appear after release.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// 3-stage pipelined floating-point multiplier with per-stage stall, four rounding modes,
// DAZ/FTZ handling of denormals, special-value propagation and per-result exception flags.
module fp_mult_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1+EXP_W+MAN_W-1:0]     a,
    input  logic [1+EXP_W+MAN_W-1:0]     b,
    input  logic [1:0]                   rm,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1+EXP_W+MAN_W-1:0]     p,
    output logic [3:0]                   flags
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned SW   = MAN_W + 1;
    localparam int unsigned PW   = 2 * SW;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX = (1 << EXP_W) - 1;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Operand classification; subnormals count as zero.
    logic a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan, sign_in;
    assign a_zero  = (a[W-2 -: EXP_W] == '0);
    assign b_zero  = (b[W-2 -: EXP_W] == '0);
    assign a_inf   = (a[W-2 -: EXP_W] == '1) && (a[MAN_W-1:0] == '0);
    assign b_inf   = (b[W-2 -: EXP_W] == '1) && (b[MAN_W-1:0] == '0);
    assign a_nan   = (a[W-2 -: EXP_W] == '1) && (a[MAN_W-1:0] != '0);
    assign b_nan   = (b[W-2 -: EXP_W] == '1) && (b[MAN_W-1:0] != '0);
    assign a_snan  = a_nan && !a[MAN_W-1];
    assign b_snan  = b_nan && !b[MAN_W-1];
    assign sign_in = a[W-1] ^ b[W-1];

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic ld1, ld2, ld3;
    assign ld3 = !v3_q || out_ready;
    assign ld2 = !v2_q || ld3;
    assign ld1 = !v1_q || ld2;

    logic          s1_sign_q, s1_sign_d, s1_spec_q, s1_spec_d, s1_nv_q, s1_nv_d;
    logic [EW-1:0] s1_exp_q, s1_exp_d;
    logic [PW-1:0] s1_prod_q, s1_prod_d;
    logic [1:0]    s1_rm_q, s1_rm_d;
    logic [W-1:0]  s1_sp_q, s1_sp_d;

    logic          s2_sign_q, s2_sign_d, s2_spec_q, s2_spec_d, s2_nv_q, s2_nv_d;
    logic          s2_g_q, s2_g_d, s2_r_q, s2_r_d, s2_s_q, s2_s_d;
    logic [EW-1:0] s2_exp_q, s2_exp_d;
    logic [SW-1:0] s2_mant_q, s2_mant_d;
    logic [1:0]    s2_rm_q, s2_rm_d;
    logic [W-1:0]  s2_sp_q, s2_sp_d;

    logic [W-1:0]  p_q, p_d;
    logic [3:0]    flags_q, flags_d;

    logic          msb, grs, inc, carry, to_inf;
    logic [PW-1:0] norm;
    logic [SW:0]   mant_r;
    logic [EW-1:0] exp_r;

    always_comb begin
        v1_d = v1_q; v2_d = v2_q; v3_d = v3_q;
        s1_sign_d = s1_sign_q; s1_spec_d = s1_spec_q; s1_nv_d = s1_nv_q;
        s1_exp_d = s1_exp_q; s1_prod_d = s1_prod_q; s1_rm_d = s1_rm_q; s1_sp_d = s1_sp_q;
        s2_sign_d = s2_sign_q; s2_spec_d = s2_spec_q; s2_nv_d = s2_nv_q;
        s2_g_d = s2_g_q; s2_r_d = s2_r_q; s2_s_d = s2_s_q;
        s2_exp_d = s2_exp_q; s2_mant_d = s2_mant_q; s2_rm_d = s2_rm_q; s2_sp_d = s2_sp_q;
        p_d = p_q; flags_d = flags_q;
        msb = 1'b0; grs = 1'b0; inc = 1'b0; carry = 1'b0; to_inf = 1'b0;
        norm = '0; mant_r = '0; exp_r = '0;

        // S1: classify, significand multiply, biased exponent sum.
        if (ld1) begin
            v1_d = in_valid;
            if (in_valid) begin
                s1_sign_d = sign_in;
                s1_exp_d  = EW'(a[W-2 -: EXP_W]) + EW'(b[W-2 -: EXP_W]) - EW'(BIAS);
                s1_prod_d = PW'({1'b1, a[MAN_W-1:0]}) * PW'({1'b1, b[MAN_W-1:0]});
                s1_rm_d   = rm;
                s1_nv_d   = a_snan || b_snan || (a_inf && b_zero) || (a_zero && b_inf);
                s1_spec_d = 1'b1;
                s1_sp_d   = '0;
                if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
                    s1_sp_d = QNAN;
                end else if (a_inf || b_inf) begin
                    s1_sp_d = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (a_zero || b_zero) begin
                    s1_sp_d = {sign_in, {(W-1){1'b0}}};
                end else begin
                    s1_spec_d = 1'b0;
                end
            end
        end

        // S2: normalise so the product MSB sits at the top, then split off G/R/S.
        if (ld2) begin
            v2_d = v1_q;
            if (v1_q) begin
                msb       = s1_prod_q[PW-1];
                norm      = msb ? s1_prod_q : (s1_prod_q << 1);
                s2_mant_d = norm[PW-1 -: SW];
                s2_g_d    = norm[MAN_W];
                s2_r_d    = norm[MAN_W-1];
                s2_s_d    = |norm[MAN_W-2:0];
                s2_exp_d  = s1_exp_q + EW'(msb);
                s2_sign_d = s1_sign_q;
                s2_spec_d = s1_spec_q;
                s2_nv_d   = s1_nv_q;
                s2_sp_d   = s1_sp_q;
                s2_rm_d   = s1_rm_q;
            end
        end

        // S3: round, resolve overflow/underflow, pack.
        if (ld3) begin
            v3_d = v2_q;
            if (v2_q) begin
                grs = s2_g_q || s2_r_q || s2_s_q;
                unique case (s2_rm_q)
                    RM_RNE:  inc = s2_g_q && (s2_r_q || s2_s_q || s2_mant_q[0]);
                    RM_RTZ:  inc = 1'b0;
                    RM_RUP:  inc = grs && !s2_sign_q;
                    default: inc = grs && s2_sign_q;
                endcase
                mant_r = (SW+1)'(s2_mant_q) + (SW+1)'(inc);
                carry  = mant_r[SW];
                exp_r  = s2_exp_q + EW'(carry);
                to_inf = (s2_rm_q == RM_RNE) || ((s2_rm_q == RM_RUP) && !s2_sign_q) ||
                         ((s2_rm_q == 2'd3) && s2_sign_q);
                if (s2_spec_q) begin
                    p_d     = s2_sp_q;
                    flags_d = {s2_nv_q, 3'b000};
                end else if ($signed(exp_r) >= $signed(EW'(EMAX))) begin
                    flags_d = 4'b0101;
                    p_d     = to_inf ? {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                     : {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                end else if ($signed(exp_r) <= $signed(EW'(0))) begin
                    flags_d = 4'b0011;
                    p_d     = {s2_sign_q, {(W-1){1'b0}}};
                end else begin
                    flags_d = {3'b000, grs};
                    p_d     = {s2_sign_q, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
            s1_sign_q <= 1'b0; s1_spec_q <= 1'b0; s1_nv_q <= 1'b0;
            s1_exp_q <= '0; s1_prod_q <= '0; s1_rm_q <= '0; s1_sp_q <= '0;
            s2_sign_q <= 1'b0; s2_spec_q <= 1'b0; s2_nv_q <= 1'b0;
            s2_g_q <= 1'b0; s2_r_q <= 1'b0; s2_s_q <= 1'b0;
            s2_exp_q <= '0; s2_mant_q <= '0; s2_rm_q <= '0; s2_sp_q <= '0;
            p_q <= '0; flags_q <= '0;
        end else begin
            v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
            s1_sign_q <= s1_sign_d; s1_spec_q <= s1_spec_d; s1_nv_q <= s1_nv_d;
            s1_exp_q <= s1_exp_d; s1_prod_q <= s1_prod_d; s1_rm_q <= s1_rm_d; s1_sp_q <= s1_sp_d;
            s2_sign_q <= s2_sign_d; s2_spec_q <= s2_spec_d; s2_nv_q <= s2_nv_d;
            s2_g_q <= s2_g_d; s2_r_q <= s2_r_d; s2_s_q <= s2_s_d;
            s2_exp_q <= s2_exp_d; s2_mant_q <= s2_mant_d; s2_rm_q <= s2_rm_d; s2_sp_q <= s2_sp_d;
            p_q <= p_d; flags_q <= flags_d;
        end
    end

    assign in_ready  = ld1;
    assign out_valid = v3_q;
    assign p         = p_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe (single precision) against an integer-arithmetic model.
module tb_fp_mult_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, p;
    logic [1:0]  rm;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [35:0] expq[$];

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .flags(flags)
    );

    always #5 clk = ~clk;

    // Reference: exact integer product, rounding decided by comparing the dropped part to one half.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
        logic s, xz, yz, xi, yi, xn, yn, xs, ys, up, inx, toinf;
        int ex, ey, e, sh;
        longint unsigned mx, my, prod, keep, rem, half;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0); yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0); yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0); yn = (ey == 255) && (y[22:0] != 0);
        xs = xn && !x[22]; ys = yn && !y[22];
        if (xn || yn) return {(xs || ys) ? 4'b1000 : 4'b0000, 32'h7FC00000};
        if ((xi && yz) || (xz && yi)) return {4'b1000, 32'h7FC00000};
        if (xi || yi) return {4'b0000, s, 8'hFF, 23'h0};
        if (xz || yz) return {4'b0000, s, 31'h0};
        mx   = (64'd1 << 23) | 64'(x[22:0]);
        my   = (64'd1 << 23) | 64'(y[22:0]);
        prod = mx * my;
        e    = ex + ey - 127;
        sh   = (prod >= (64'd1 << 47)) ? 24 : 23;
        e    = e + sh - 23;
        keep = prod >> sh;
        rem  = prod & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        case (m)
            2'd0:    up = (rem > half) || ((rem == half) && keep[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = inx && !s;
            default: up = inx && s;
        endcase
        keep = keep + 64'(up);
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            toinf = (m == 2'd0) || ((m == 2'd2) && !s) || ((m == 2'd3) && s);
            return {4'b0101, toinf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF}};
        end
        if (e <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, inx, s, 8'(e), keep[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [31:0] f;
        case ($urandom % 8)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom);
            default: e = 8'(100 + ($urandom % 56));
        endcase
        f = $urandom;
        if ($urandom % 6 == 0) f = 32'h0;
        return {1'($urandom), e, f[22:0]};
    endfunction

    // One cycle: drive at negedge, then check outputs and log an accepted operand set.
    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [1:0] irm, input logic ordy, output logic accepted);
        @(negedge clk);
        in_valid = iv; a = ia; b = ib; rm = irm; out_ready = ordy;
        #1;
        if (out_valid) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got p=%h flags=%b with nothing outstanding", p, flags);
            end else begin
                if ({flags, p} !== expq[0]) begin
                    errors++;
                    $display("FAIL result: got p=%h flags=%b expected p=%h flags=%b",
                             p, flags, expq[0][31:0], expq[0][35:32]);
                end
                if (out_ready) void'(expq.pop_front());
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            expq.push_back(model(ia, ib, irm));
            acc_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic send(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] irm);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) step(1'b1, ia, ib, irm, 1'b1, acc);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 60 && expq.size() != 0; i++) step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, acc);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d results outstanding expected 0", expq.size());
        end
    endtask

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    typedef struct { logic [31:0] x; logic [31:0] y; logic [1:0] m; logic [31:0] ep; logic [3:0] ef; } vec_t;
    vec_t vecs[13];

    initial begin
        logic acc;
        int   n, lat;
        vecs[0]  = '{32'h40400000, 32'h40000000, 2'd0, 32'h40C00000, 4'b0000};
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'b0001};
        vecs[2]  = '{32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 4'b0001};
        vecs[3]  = '{32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'b0001};
        vecs[4]  = '{32'h3F800001, 32'h3F800001, 2'd3, 32'h3F800002, 4'b0001};
        vecs[5]  = '{32'h7F7FFFFF, 32'h40000000, 2'd0, 32'h7F800000, 4'b0101};
        vecs[6]  = '{32'h7F7FFFFF, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'b0101};
        vecs[7]  = '{32'hFF7FFFFF, 32'h40000000, 2'd2, 32'hFF7FFFFF, 4'b0101};
        vecs[8]  = '{32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 4'b1000};
        vecs[9]  = '{32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b1000};
        vecs[10] = '{32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 4'b0000};
        vecs[11] = '{32'h00800000, 32'h3F000000, 2'd0, 32'h00000000, 4'b0011};
        vecs[12] = '{32'h00000001, 32'h7F000000, 2'd0, 32'h00000000, 4'b0000};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; rm = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {30'd0, out_valid, in_ready, flags, p}, {30'd0, 1'b0, 1'b1, 4'b0, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;

        // Pin the model to hand-computed results.
        foreach (vecs[i]) chk($sformatf("model_vec%0d", i), model(vecs[i].x, vecs[i].y, vecs[i].m),
                              {vecs[i].ef, vecs[i].ep});

        // Latency on an empty pipe.
        send(vecs[0].x, vecs[0].y, vecs[0].m);
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, acc);
            if (out_valid) lat = cyc - 1 - acc_cyc;
        end
        chk("latency", 36'(lat), 36'd3);

        foreach (vecs[i]) send(vecs[i].x, vecs[i].y, vecs[i].m);
        drain();

        // Backpressure: only three operands fit while the output is stalled.
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vecs[n].x, vecs[n].y, vecs[n].m, 1'b0, acc);
            if (acc) n++;
        end
        chk("stall_accepts", {in_ready, 35'(n)}, {1'b0, 35'd3});
        for (int i = 0; i < 40 && n < 5; i++) begin
            step(1'b1, vecs[n].x, vecs[n].y, vecs[n].m, 1'b1, acc);
            if (acc) n++;
        end
        drain();

        // Random traffic with random valid/ready.
        n = 0;
        for (int i = 0; i < 3000 && n < 1500; i++) begin
            step(($urandom % 4) != 0, rnd_op(), rnd_op(), 2'($urandom), ($urandom % 4) != 0, acc);
            if (acc) n++;
        end
        drain();

        // Reset mid-stream with a full, stalled pipe.
        for (int i = 0; i < 6; i++) step(1'b1, rnd_op(), rnd_op(), 2'($urandom), 1'b0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_midstream", {31'd0, out_valid, flags, p}, 36'd0);
        expq.delete();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, acc);
            chk("no_stale", 36'(out_valid), 36'd0);
        end
        send(vecs[3].x, vecs[3].y, vecs[3].m);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
